// File: rtl/sti_dac_gen2_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sti_dac_gen2_pkg
// Description : Shared types and helpers for the STI serializer / OEM packer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package sti_dac_gen2_pkg;

    localparam int BYTE_W = 8;

    // Top-level control states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_PAD   = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Frame length codes: L = (code+1) * PI_W / 2
    typedef enum logic [1:0] {
        LEN_HALF     = 2'd0,
        LEN_FULL     = 2'd1,
        LEN_ONE_HALF = 2'd2,
        LEN_DOUBLE   = 2'd3
    } len_code_t;

    // Frame length in bits for a given parallel width and length code
    function automatic int unsigned frame_len(input int unsigned width,
                                              input logic [1:0]  code);
        return ((32'(code) + 32'd1) * width) / 32'd2;
    endfunction

endpackage : sti_dac_gen2_pkg
`default_nettype wire

// File: rtl/sti_oem_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sti_oem_packer
// Description : Packs the serial bit stream into bytes, maps each byte index
//               onto the checkerboard of odd/even output banks, and supplies
//               the zero-fill writes after the final frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sti_oem_packer
    import sti_dac_gen2_pkg::*;
#(
    parameter int NUM_BANK = 8,
    parameter int AW       = 5,
    parameter int ROW_PIX  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_valid,
    input  logic                bit_data,
    input  logic                pad,
    input  logic                fill,
    output logic [NUM_BANK-1:0] oem_wr,
    output logic [AW-1:0]       oem_addr,
    output logic [BYTE_W-1:0]   oem_dataout,
    output logic                all_written
);
    localparam int TOTAL = NUM_BANK * (2 ** AW);
    localparam int IW    = $clog2(TOTAL) + 1;
    localparam int RPW   = $clog2(ROW_PIX);
    localparam int BW    = $clog2(NUM_BANK);
    localparam logic [IW-1:0] C_TOTAL     = IW'(TOTAL);
    localparam logic [BW-1:0] C_EVEN_BASE = BW'(NUM_BANK / 2);

    logic [IW-1:0]       r_index;
    logic [2:0]          r_bitcnt;
    logic [BYTE_W-1:0]   r_byte;

    logic [BYTE_W-1:0]   w_byte_next;
    logic [BYTE_W-1:0]   w_pad_byte;
    logic [BYTE_W-1:0]   w_emit_data;
    logic                w_emit;
    logic                w_parity;
    logic [BW-1:0]       w_offset;
    logic [BW-1:0]       w_bank;
    logic [NUM_BANK-1:0] w_onehot;

    // First bit received ends up in the MSB after eight shifts
    assign w_byte_next = {r_byte[BYTE_W-2:0], bit_data};
    // Partial byte holds r_bitcnt bits in its LSBs; move them to the top
    assign w_pad_byte  = r_byte << (3'd0 - r_bitcnt);

    // Pixel parity (row + column) selects the odd or even bank group
    assign w_parity    = r_index[RPW] ^ r_index[0];
    assign w_offset    = BW'(r_index >> (AW + 1));
    assign w_bank      = w_parity ? w_offset : (w_offset + C_EVEN_BASE);
    assign w_onehot    = NUM_BANK'(1) << w_bank;
    assign all_written = (r_index == C_TOTAL);

    // Select what, if anything, is written this cycle
    always_comb begin
        w_emit      = 1'b0;
        w_emit_data = '0;
        if (bit_valid && (r_bitcnt == 3'd7)) begin
            w_emit      = 1'b1;
            w_emit_data = w_byte_next;
        end else if (pad && (r_bitcnt != 3'd0)) begin
            w_emit      = 1'b1;
            w_emit_data = w_pad_byte;
        end else if (fill) begin
            w_emit      = 1'b1;
            w_emit_data = '0;
        end
    end

    // Byte assembly, index tracking and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index     <= '0;
            r_bitcnt    <= '0;
            r_byte      <= '0;
            oem_wr      <= '0;
            oem_addr    <= '0;
            oem_dataout <= '0;
        end else begin
            oem_wr <= '0;
            if (bit_valid) begin
                r_byte   <= (r_bitcnt == 3'd7) ? '0 : w_byte_next;
                r_bitcnt <= r_bitcnt + 3'd1;
            end else if (pad) begin
                r_byte   <= '0;
                r_bitcnt <= '0;
            end
            // Past the last location the index saturates and bytes are dropped
            if (w_emit && !all_written) begin
                oem_wr      <= w_onehot;
                oem_addr    <= r_index[AW:1];
                oem_dataout <= w_emit_data;
                r_index     <= r_index + IW'(1);
            end
        end
    end

endmodule : sti_oem_packer
`default_nettype wire

// File: rtl/sti_dac_gen2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sti_dac_gen2
// Description : Parallel-to-serial frame transmitter with zero extension,
//               selectable bit order, and byte packing into banked memories.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sti_dac_gen2
    import sti_dac_gen2_pkg::*;
#(
    parameter int PI_W     = 16,
    parameter int NUM_BANK = 8,
    parameter int AW       = 5,
    parameter int ROW_PIX  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    output logic                ready,
    input  logic [PI_W-1:0]     pi_data,
    input  logic [1:0]          pi_length,
    input  logic                pi_fill,
    input  logic                pi_msb,
    input  logic                pi_low,
    input  logic                pi_end,
    output logic                so_data,
    output logic                so_valid,
    output logic [NUM_BANK-1:0] oem_wr,
    output logic [AW-1:0]       oem_addr,
    output logic [BYTE_W-1:0]   oem_dataout,
    output logic                oem_finish
);
    localparam int FW = 2 * PI_W;
    localparam int HW = PI_W / 2;
    localparam int CW = $clog2(FW);

    state_t        r_state;
    logic [FW-1:0] r_shreg;
    logic [CW-1:0] r_remain;
    logic          r_msb;
    logic          r_end;

    logic [HW-1:0] w_half;
    logic [FW-1:0] w_frame;
    logic [FW-1:0] w_aligned;
    int unsigned   w_len;
    logic          w_first;
    logic          w_pad;
    logic          w_fill;
    logic          w_all_written;

    assign w_half    = pi_low ? pi_data[HW-1:0] : pi_data[PI_W-1:HW];
    assign w_len     = frame_len(PI_W, pi_length);
    // MSB-first frames are left-aligned so the next bit is always the top bit
    assign w_aligned = pi_msb ? (w_frame << (FW - w_len)) : w_frame;
    assign w_first   = pi_msb ? w_aligned[FW-1] : w_aligned[0];
    assign w_pad     = (r_state == S_PAD);
    assign w_fill    = (r_state == S_FILL);

    // Right-aligned frame image including any zero extension
    always_comb begin
        w_frame = '0;
        case (len_code_t'(pi_length))
            LEN_HALF:     w_frame = FW'(w_half);
            LEN_FULL:     w_frame = FW'(pi_data);
            LEN_ONE_HALF: w_frame = pi_fill ? FW'({pi_data, {HW{1'b0}}}) : FW'(pi_data);
            LEN_DOUBLE:   w_frame = pi_fill ? {pi_data, {PI_W{1'b0}}} : FW'(pi_data);
            default:      w_frame = '0;
        endcase
    end

    // Control FSM with registered handshake and serial outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_remain   <= '0;
            r_msb      <= 1'b0;
            r_end      <= 1'b0;
            ready      <= 1'b1;
            so_data    <= 1'b0;
            so_valid   <= 1'b0;
            oem_finish <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ready && load) begin
                        r_shreg  <= pi_msb ? (w_aligned << 1) : (w_aligned >> 1);
                        r_remain <= CW'(w_len - 32'd1);
                        r_msb    <= pi_msb;
                        r_end    <= pi_end;
                        so_data  <= w_first;
                        so_valid <= 1'b1;
                        ready    <= 1'b0;
                        r_state  <= S_SHIFT;
                    end else begin
                        // One idle cycle with ready low separates frames
                        ready <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_remain == '0) begin
                        so_valid <= 1'b0;
                        so_data  <= 1'b0;
                        r_state  <= r_end ? S_PAD : S_IDLE;
                    end else begin
                        so_data  <= r_msb ? r_shreg[FW-1] : r_shreg[0];
                        r_shreg  <= r_msb ? (r_shreg << 1) : (r_shreg >> 1);
                        r_remain <= r_remain - CW'(1);
                    end
                end
                S_PAD: begin
                    r_state <= S_FILL;
                end
                S_FILL: begin
                    if (w_all_written) begin
                        oem_finish <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    oem_finish <= 1'b1;
                    ready      <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sti_oem_packer #(
        .NUM_BANK (NUM_BANK),
        .AW       (AW),
        .ROW_PIX  (ROW_PIX)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (so_valid),
        .bit_data    (so_data),
        .pad         (w_pad),
        .fill        (w_fill),
        .oem_wr      (oem_wr),
        .oem_addr    (oem_addr),
        .oem_dataout (oem_dataout),
        .all_written (w_all_written)
    );

endmodule : sti_dac_gen2
`default_nettype wire

// File: tb/tb_sti_dac_gen2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sti_dac_gen2
// Description : Directed self-checking bench for sti_dac_gen2.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sti_dac_gen2;
    localparam int PI_W     = 16;
    localparam int NUM_BANK = 8;
    localparam int AW       = 5;
    localparam int ROW_PIX  = 8;
    localparam int TOTAL    = NUM_BANK * (2 ** AW);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                load = 1'b0;
    logic                ready;
    logic [PI_W-1:0]     pi_data = '0;
    logic [1:0]          pi_length = '0;
    logic                pi_fill = 1'b0;
    logic                pi_msb = 1'b0;
    logic                pi_low = 1'b0;
    logic                pi_end = 1'b0;
    logic                so_data;
    logic                so_valid;
    logic [NUM_BANK-1:0] oem_wr;
    logic [AW-1:0]       oem_addr;
    logic [7:0]          oem_dataout;
    logic                oem_finish;

    typedef struct packed {
        logic [7:0] wr;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wlog[$];
    int  checks = 0;
    int  errors = 0;
    int  bad_strobe = 0;

    always #5 clk = ~clk;

    sti_dac_gen2 #(
        .PI_W(PI_W), .NUM_BANK(NUM_BANK), .AW(AW), .ROW_PIX(ROW_PIX)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .ready(ready),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid),
        .oem_wr(oem_wr), .oem_addr(oem_addr), .oem_dataout(oem_dataout),
        .oem_finish(oem_finish)
    );

    // Write recorder, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (oem_wr != '0) begin
            wlog.push_back(wr_t'({oem_wr, oem_addr, oem_dataout}));
            if ($countones(oem_wr) != 1) bad_strobe++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wlog.delete();
    endtask

    // Waits for ready, issues one load, captures n serial bits.
    // exp holds the bits in transmit order, first bit at exp[n-1].
    // Returns at the first cycle after the frame (so_valid expected low).
    task automatic send_frame(input string tag, input logic [15:0] d, input logic [1:0] len,
                              input logic fill, input logic msb, input logic low,
                              input logic fin, input logic [31:0] exp, input int n,
                              input logic hold);
        int          waited = 0;
        int          vcount = 0;
        logic [31:0] got = '0;
        while (ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready_before"}, 32'(ready), 32'd1);
        pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb;
        pi_low = low; pi_end = fin; load = 1'b1;
        @(negedge clk);
        if (!hold) load = 1'b0;
        check({tag, "_ready_busy"}, 32'(ready), 32'd0);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (so_valid === 1'b1) vcount++;
            got[n-1-k] = so_data;
        end
        check({tag, "_valid_run"}, vcount, n);
        check({tag, "_bits"}, got, exp);
        @(negedge clk);
        check({tag, "_valid_end"}, 32'(so_valid), 32'd0);
    endtask

    initial begin
        int waited;
        int map_bad;
        int nz;
        int dup;
        int r, c, p, off, b, key;
        logic seen [0:TOTAL-1];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_so_valid", 32'(so_valid), 32'd0);
        check("rst_so_data", 32'(so_data), 32'd0);
        check("rst_oem_wr", 32'(oem_wr), 32'd0);
        check("rst_finish", 32'(oem_finish), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_addr", 32'(oem_addr), 32'd0);
        check("rst_dout", 32'(oem_dataout), 32'd0);

        // Half-word frame, low half, MSB first
        send_frame("A", 16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000C3, 8, 1'b0);
        check("A_wr", 32'(oem_wr), 32'h10);
        check("A_addr", 32'(oem_addr), 32'd0);
        check("A_dout", 32'(oem_dataout), 32'hC3);
        @(negedge clk);
        check("A_ready_after", 32'(ready), 32'd1);

        // Prepended zeros, MSB first
        do_reset();
        send_frame("B", 16'h1234, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00001234, 24, 1'b0);
        check("B_nwr", wlog.size(), 3);
        check("B_w0", 32'(wlog[0]), 32'({8'h10, 5'd0, 8'h00}));
        check("B_w1", 32'(wlog[1]), 32'({8'h01, 5'd0, 8'h12}));
        check("B_w2", 32'(wlog[2]), 32'({8'h10, 5'd1, 8'h34}));

        // Appended zeros, LSB first, load held high (handshake)
        send_frame("C", 16'h8001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00008001, 32, 1'b1);
        check("C_ready_gap", 32'(ready), 32'd0);
        @(negedge clk);
        check("C_ready_back", 32'(ready), 32'd1);
        check("C_no_overlap", 32'(so_valid), 32'd0);
        @(negedge clk);
        check("C_restart", 32'(so_valid), 32'd1);
        load = 1'b0;
        check("C_nwr", wlog.size(), 7);
        check("C_w3", 32'(wlog[3]), 32'({8'h01, 5'd1, 8'h00}));
        check("C_w4", 32'(wlog[4]), 32'({8'h10, 5'd2, 8'h00}));
        check("C_w5", 32'(wlog[5]), 32'({8'h01, 5'd2, 8'h80}));
        check("C_w6", 32'(wlog[6]), 32'({8'h10, 5'd3, 8'h01}));

        // High half, LSB first: byte index 11 -> row 1 col 3, even bank 4, addr 5
        send_frame("D", 16'hC15A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000083, 8, 1'b0);
        check("D_wr", 32'(oem_wr), 32'h10);
        check("D_addr", 32'(oem_addr), 32'd5);
        check("D_dout", 32'(oem_dataout), 32'h83);

        // Full-width frame, LSB first: bytes 0F (idx 12) and 48 (idx 13)
        send_frame("E", 16'h12F0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000F48, 16, 1'b0);
        check("E_w12", 32'(wlog[12]), 32'({8'h01, 5'd6, 8'h0F}));
        check("E_w13", 32'(wlog[13]), 32'({8'h10, 5'd6, 8'h48}));

        // Reset at bit 5 of a 32-bit frame
        waited = 0;
        while (ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("F_ready_before", 32'(ready), 32'd1);
        pi_data = 16'hFFFF; pi_length = 2'd3; pi_fill = 1'b1; pi_msb = 1'b1;
        pi_low = 1'b0; pi_end = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check("F_valid_bit5", 32'(so_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("F_valid_killed", 32'(so_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("F_ready_after", 32'(ready), 32'd1);
        check("F_valid_idle", 32'(so_valid), 32'd0);
        wlog.delete();
        send_frame("G", 16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000C3, 8, 1'b0);
        check("G_wr", 32'(oem_wr), 32'h10);
        check("G_addr", 32'(oem_addr), 32'd0);
        check("G_dout", 32'(oem_dataout), 32'hC3);

        // Overflow: 65 frames of 4 bytes, last 4 bytes dropped
        do_reset();
        for (int i = 0; i < 65; i++) begin
            send_frame("H", 16'hC300 | 16'(i), 2'd3, 1'b0, 1'b1, 1'b0, 1'b0,
                       {16'h0000, 16'hC300 | 16'(i)}, 32, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("H_nwr", wlog.size(), TOTAL);
        check("H_last", 32'(wlog[TOTAL-1]), 32'({8'h80, 5'd31, 8'h3F}));
        check("H_no_finish", 32'(oem_finish), 32'd0);

        // Single end frame followed by zero fill of the whole memory
        do_reset();
        send_frame("END", 16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000C3, 8, 1'b0);
        check("END_ready_low", 32'(ready), 32'd0);
        waited = 0;
        while (oem_finish !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("END_finish", 32'(oem_finish), 32'd1);
        check("END_nwr", wlog.size(), TOTAL);
        check("END_w0", 32'(wlog[0]), 32'({8'h10, 5'd0, 8'hC3}));
        map_bad = 0;
        nz = 0;
        dup = 0;
        for (int k = 0; k < TOTAL; k++) seen[k] = 1'b0;
        for (int k = 0; k < wlog.size(); k++) begin
            r   = k / ROW_PIX;
            c   = k % ROW_PIX;
            p   = (r + c) % 2;
            off = k / (2 ** (AW + 1));
            b   = (p == 1) ? off : (NUM_BANK / 2 + off);
            if (wlog[k].wr !== 8'(1 << b) || wlog[k].addr !== 5'((k % (2 ** (AW + 1))) / 2))
                map_bad++;
            if (k > 0 && wlog[k].data !== 8'h00) nz++;
            key = $clog2(int'(wlog[k].wr)) * (2 ** AW) + int'(wlog[k].addr);
            if (key >= 0 && key < TOTAL) begin
                if (seen[key]) dup++;
                seen[key] = 1'b1;
            end
        end
        check("END_mapping", map_bad, 0);
        check("END_zero_fill", nz, 0);
        check("END_once", dup, 0);
        repeat (5) @(negedge clk);
        check("END_finish_held", 32'(oem_finish), 32'd1);
        check("END_ready_held", 32'(ready), 32'd0);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("END_load_ignored", 32'(so_valid), 32'd0);
        check("strobe_onehot", bad_strobe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sti_dac_gen2
`default_nettype wire
